// File: rtl/arvi_alu_arb_pkg.sv
// rtl/arvi_alu_arb_pkg.sv - shared types and constants for the ALU arbiter slice
package arvi_alu_arb_pkg;

    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic            lock;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU; unknown opcodes yield zero
module alu
    import arvi_alu_arb_pkg::*;
(
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y,
    output logic            z
);

    localparam int SH = $clog2(XLEN);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLL:  y = a << b[SH-1:0];
            ALU_SRL:  y = a >> b[SH-1:0];
            ALU_SRA:  y = $signed(a) >>> b[SH-1:0];
            ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
            default:  y = '0;
        endcase
    end

    assign z = (y == '0);

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting just after ptr
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    int   k;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(ptr) + i) % N;
            if (!found && req[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = IW'(k);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU with per-requester lock and watchdog
module alu_arbiter
    import arvi_alu_arb_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int LOCK_MAX = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic [N_REQ-1:0]           i_req_valid,
    output logic [N_REQ-1:0]           o_req_ready,
    input  logic [N_REQ-1:0]           i_req_lock,
    input  logic [N_REQ*4-1:0]         i_req_op,
    input  logic [N_REQ*XLEN-1:0]      i_req_a,
    input  logic [N_REQ*XLEN-1:0]      i_req_b,
    output logic [N_REQ-1:0]           o_rsp_valid,
    output logic [XLEN-1:0]            o_rsp_data,
    output logic                       o_rsp_z,
    output logic [$clog2(N_REQ)-1:0]   o_owner,
    output logic                       o_locked,
    output logic                       o_lock_abort
);

    localparam int IW   = $clog2(N_REQ);
    localparam int WD_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (LOCK_MAX > 0) ? WD_W'(LOCK_MAX - 1) : '0;

    lock_state_e      state;
    lock_state_e      state_nxt;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    arb_idx;
    logic [IW-1:0]    gnt_idx;
    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] arb_grant;
    logic [N_REQ-1:0] ready;
    logic [WD_W-1:0]  wd;
    logic             xfer;
    logic             timeout;
    logic             abort;
    alu_req_t         reqs [N_REQ];
    alu_req_t         sel;
    logic [XLEN-1:0]  alu_y;
    logic             alu_z;
    logic [N_REQ-1:0] rsp_valid;
    logic [XLEN-1:0]  rsp_data;
    logic             rsp_z;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign reqs[k] = '{op:   i_req_op[4*k +: 4],
                           a:    i_req_a[XLEN*k +: XLEN],
                           b:    i_req_b[XLEN*k +: XLEN],
                           lock: i_req_lock[k]};
    end

    // Arbiter only sees requests while unlocked; the owner bypasses it.
    assign arb_req = (state == UNLOCKED) ? i_req_valid : '0;

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .req   (arb_req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_comb begin
        ready   = arb_grant;
        gnt_idx = arb_idx;
        if (state == LOCKED) begin
            ready        = '0;
            ready[owner] = i_req_valid[owner];
            gnt_idx      = owner;
        end
    end

    assign xfer    = |ready;
    assign sel     = xfer ? reqs[gnt_idx] : '0;
    assign timeout = (LOCK_MAX != 0) && (state == LOCKED) && !xfer && (wd == WD_LAST);

    alu u_alu (
        .op (sel.op),
        .a  (sel.a),
        .b  (sel.b),
        .y  (alu_y),
        .z  (alu_z)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= UNLOCKED;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: if (xfer && sel.lock) state_nxt = LOCKED;
            LOCKED: begin
                if (xfer)         state_nxt = sel.lock ? LOCKED : UNLOCKED;
                else if (timeout) state_nxt = UNLOCKED;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ptr       <= IW'(N_REQ - 1);
            owner     <= '0;
            wd        <= '0;
            abort     <= 1'b0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_z     <= 1'b0;
        end else begin
            abort     <= timeout;
            rsp_valid <= ready;
            if (xfer) begin
                rsp_data <= alu_y;
                rsp_z    <= alu_z;
            end
            if (state == UNLOCKED && xfer) begin
                ptr <= gnt_idx;
                if (sel.lock) owner <= gnt_idx;
            end
            // A timed-out owner goes to the back of the rotation.
            if (timeout) ptr <= owner;
            if (state == LOCKED && !xfer && !timeout && LOCK_MAX != 0) wd <= wd + 1'b1;
            else                                                      wd <= '0;
        end
    end

    assign o_req_ready  = ready;
    assign o_rsp_valid  = rsp_valid;
    assign o_rsp_data   = rsp_data;
    assign o_rsp_z      = rsp_z;
    assign o_owner      = owner;
    assign o_locked     = (state == LOCKED);
    assign o_lock_abort = abort;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import arvi_alu_arb_pkg::*;

    localparam int N  = 2;
    localparam int LM = 4;

    logic            clk  = 1'b0;
    logic            rstn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_lock  = '0;
    logic [N*4-1:0]  req_op    = '0;
    logic [N*XLEN-1:0] req_a   = '0;
    logic [N*XLEN-1:0] req_b   = '0;
    logic [N-1:0]    ready;
    logic [N-1:0]    rsp_valid;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_z;
    logic            owner;
    logic            locked;
    logic            abort;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N_REQ(N), .LOCK_MAX(LM)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_req_valid  (req_valid),
        .o_req_ready  (ready),
        .i_req_lock   (req_lock),
        .i_req_op     (req_op),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_data   (rsp_data),
        .o_rsp_z      (rsp_z),
        .o_owner      (owner),
        .o_locked     (locked),
        .o_lock_abort (abort)
    );

    task automatic set_req(input int k, input logic v, input logic lk, input logic [3:0] op,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        req_valid[k]           = v;
        req_lock[k]            = lk;
        req_op[4*k +: 4]       = op;
        req_a[XLEN*k +: XLEN]  = a;
        req_b[XLEN*k +: XLEN]  = b;
    endtask

    task automatic idle_all();
        req_valid = '0;
        req_lock  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_all();
        rstn = 1'b0;
        next_cycle();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        idle_all();
        rstn = 1'b0;
        #3;
        if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end checks++;
        if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end checks++;
        if (rsp_z !== 1'b0) begin errors++; $display("FAIL reset_rsp_z got %b want 0", rsp_z); end checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end checks++;
        if (owner !== 1'b0) begin errors++; $display("FAIL reset_owner got %b want 0", owner); end checks++;
        if (abort !== 1'b0) begin errors++; $display("FAIL reset_abort got %b want 0", abort); end checks++;
        next_cycle();
        rstn = 1'b1;
    endtask

    task automatic test_add();
        set_req(0, 1'b1, 1'b0, ALU_ADD, 32'd5, 32'd7);
        #1;
        if (ready !== 2'b01) begin errors++; $display("FAIL add_ready got %b want 01", ready); end checks++;
        next_cycle();
        idle_all();
        #1;
        if (rsp_valid !== 2'b01) begin errors++; $display("FAIL add_rsp_valid got %b want 01", rsp_valid); end checks++;
        if (rsp_data !== 32'd12) begin errors++; $display("FAIL add_data got %0d want 12", rsp_data); end checks++;
        if (rsp_z !== 1'b0) begin errors++; $display("FAIL add_z got %b want 0", rsp_z); end checks++;
        next_cycle();
        if (rsp_valid !== 2'b00) begin errors++; $display("FAIL idle_rsp_valid got %b want 00", rsp_valid); end checks++;
        if (rsp_data !== 32'd12) begin errors++; $display("FAIL idle_hold_data got %0d want 12", rsp_data); end checks++;
    endtask

    task automatic test_rotation();
        logic [1:0]      exp_g [4];
        logic [XLEN-1:0] exp_d [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_d = '{32'd2, 32'd5, 32'd2, 32'd5};
        do_reset();
        set_req(0, 1'b1, 1'b0, ALU_ADD, 32'd1, 32'd1);
        set_req(1, 1'b1, 1'b0, ALU_ADD, 32'd2, 32'd3);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (ready !== exp_g[i]) begin errors++; $display("FAIL rot_ready[%0d] got %b want %b", i, ready, exp_g[i]); end checks++;
            if (i > 0) begin
                if (rsp_valid !== exp_g[i-1]) begin errors++; $display("FAIL rot_rsp_valid[%0d] got %b want %b", i, rsp_valid, exp_g[i-1]); end checks++;
                if (rsp_data !== exp_d[i-1]) begin errors++; $display("FAIL rot_data[%0d] got %0d want %0d", i, rsp_data, exp_d[i-1]); end checks++;
            end
            next_cycle();
        end
        idle_all();
        #1;
        if (rsp_valid !== 2'b10) begin errors++; $display("FAIL rot_last_rsp got %b want 10", rsp_valid); end checks++;
        next_cycle();
    endtask

    task automatic issue(input int k, input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        set_req(k, 1'b1, 1'b0, op, a, b);
        next_cycle();
        idle_all();
        #1;
    endtask

    task automatic test_ops();
        issue(1, ALU_SUB, 32'd9, 32'd9);
        if (rsp_valid !== 2'b10) begin errors++; $display("FAIL sub_rsp_valid got %b want 10", rsp_valid); end checks++;
        if (rsp_data !== 32'd0) begin errors++; $display("FAIL sub_data got %0d want 0", rsp_data); end checks++;
        if (rsp_z !== 1'b1) begin errors++; $display("FAIL sub_z got %b want 1", rsp_z); end checks++;
        issue(0, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        if (rsp_data !== 32'd1) begin errors++; $display("FAIL slt_data got %0d want 1", rsp_data); end checks++;
        if (rsp_z !== 1'b0) begin errors++; $display("FAIL slt_z got %b want 0", rsp_z); end checks++;
        issue(0, ALU_SLTU, 32'hFFFF_FFFF, 32'd1);
        if (rsp_data !== 32'd0) begin errors++; $display("FAIL sltu_data got %0d want 0", rsp_data); end checks++;
        issue(0, ALU_ADD, 32'd2, 32'd2);
        if (rsp_data !== 32'd4) begin errors++; $display("FAIL add2_data got %0d want 4", rsp_data); end checks++;
        issue(1, 4'hF, 32'd3, 32'd4);
        if (rsp_data !== 32'd0) begin errors++; $display("FAIL badop_data got %0d want 0", rsp_data); end checks++;
        if (rsp_z !== 1'b1) begin errors++; $display("FAIL badop_z got %b want 1", rsp_z); end checks++;
        next_cycle();
    endtask

    task automatic test_lock();
        do_reset();
        set_req(0, 1'b1, 1'b1, ALU_ADD, 32'd1, 32'd2);
        #1;
        if (ready !== 2'b01) begin errors++; $display("FAIL lock_first_ready got %b want 01", ready); end checks++;
        next_cycle();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b0, ALU_ADD, 32'd10, 32'd20);
        for (int c = 0; c < 3; c++) begin
            #1;
            if (ready !== 2'b00) begin errors++; $display("FAIL lock_block_ready[%0d] got %b want 00", c, ready); end checks++;
            if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked[%0d] got %b want 1", c, locked); end checks++;
            if (owner !== 1'b0) begin errors++; $display("FAIL lock_owner[%0d] got %b want 0", c, owner); end checks++;
            if (c == 0 && rsp_data !== 32'd3) begin errors++; $display("FAIL lock_first_data got %0d want 3", rsp_data); end
            if (c == 0) checks++;
            next_cycle();
        end
        // Owner releases on the cycle the watchdog would otherwise expire.
        set_req(0, 1'b1, 1'b0, ALU_ADD, 32'd4, 32'd4);
        #1;
        if (ready !== 2'b01) begin errors++; $display("FAIL unlock_ready got %b want 01", ready); end checks++;
        next_cycle();
        req_valid[0] = 1'b0;
        #1;
        if (locked !== 1'b0) begin errors++; $display("FAIL unlock_locked got %b want 0", locked); end checks++;
        if (abort !== 1'b0) begin errors++; $display("FAIL unlock_abort got %b want 0", abort); end checks++;
        if (rsp_data !== 32'd8) begin errors++; $display("FAIL unlock_data got %0d want 8", rsp_data); end checks++;
        if (ready !== 2'b10) begin errors++; $display("FAIL unlock_req1_ready got %b want 10", ready); end checks++;
        next_cycle();
        idle_all();
        #1;
        if (rsp_valid !== 2'b10) begin errors++; $display("FAIL unlock_req1_rsp got %b want 10", rsp_valid); end checks++;
        if (rsp_data !== 32'd30) begin errors++; $display("FAIL unlock_req1_data got %0d want 30", rsp_data); end checks++;
        next_cycle();
    endtask

    task automatic test_watchdog();
        do_reset();
        set_req(0, 1'b1, 1'b1, ALU_ADD, 32'd1, 32'd1);
        next_cycle();
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 1'b0, ALU_ADD, 32'd7, 32'd8);
        for (int c = 0; c < LM; c++) begin
            #1;
            if (abort !== 1'b0) begin errors++; $display("FAIL wd_early_abort[%0d] got %b want 0", c, abort); end checks++;
            if (locked !== 1'b1) begin errors++; $display("FAIL wd_locked[%0d] got %b want 1", c, locked); end checks++;
            next_cycle();
        end
        set_req(0, 1'b1, 1'b0, ALU_ADD, 32'd2, 32'd2);
        #1;
        if (abort !== 1'b1) begin errors++; $display("FAIL wd_abort got %b want 1", abort); end checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL wd_unlocked got %b want 0", locked); end checks++;
        if (ready !== 2'b10) begin errors++; $display("FAIL wd_owner_last got %b want 10", ready); end checks++;
        next_cycle();
        req_valid[1] = 1'b0;
        #1;
        if (abort !== 1'b0) begin errors++; $display("FAIL wd_abort_pulse got %b want 0", abort); end checks++;
        if (rsp_data !== 32'd15) begin errors++; $display("FAIL wd_req1_data got %0d want 15", rsp_data); end checks++;
        if (ready !== 2'b01) begin errors++; $display("FAIL wd_req0_next got %b want 01", ready); end checks++;
        next_cycle();
        idle_all();
        #1;
        if (rsp_valid !== 2'b01) begin errors++; $display("FAIL wd_req0_rsp got %b want 01", rsp_valid); end checks++;
        if (rsp_data !== 32'd4) begin errors++; $display("FAIL wd_req0_data got %0d want 4", rsp_data); end checks++;
        next_cycle();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        set_req(0, 1'b1, 1'b1, ALU_ADD, 32'd3, 32'd4);
        next_cycle();
        set_req(0, 1'b1, 1'b1, ALU_ADD, 32'd5, 32'd5);
        #1;
        if (locked !== 1'b1 || rsp_valid !== 2'b01) begin errors++; $display("FAIL midlock_pre got %b/%b want 1/01", locked, rsp_valid); end checks++;
        rstn = 1'b0;
        #1;
        if (rsp_valid !== 2'b00) begin errors++; $display("FAIL midlock_rsp_valid got %b want 00", rsp_valid); end checks++;
        if (rsp_data !== 32'd0) begin errors++; $display("FAIL midlock_data got %h want 0", rsp_data); end checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL midlock_locked got %b want 0", locked); end checks++;
        idle_all();
        next_cycle();
        rstn = 1'b1;
        set_req(1, 1'b1, 1'b0, ALU_ADD, 32'd1, 32'd2);
        #1;
        if (rsp_valid !== 2'b00) begin errors++; $display("FAIL midlock_dropped got %b want 00", rsp_valid); end checks++;
        if (ready !== 2'b10) begin errors++; $display("FAIL midlock_free_ready got %b want 10", ready); end checks++;
        next_cycle();
        idle_all();
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_rotation();
        test_ops();
        test_lock();
        test_watchdog();
        test_reset_mid_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
